// File: rtl/crossbar_nxn_shadow.sv
// crossbar_nxn_shadow
//   N x N registered crossbar (N = 2**SEL_W) with a double-buffered route
//   table. Configuration writes go to a shadow table; a commit copies the
//   shadow table into the active table only on a cycle with no valid input
//   traffic. All outputs therefore switch routing on the same edge.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   in_data/in_valid N input channels, channel i at in_data[i*W +: W]
//   cfg_we           write {cfg_src, cfg_en} into shadow entry cfg_port
//   cfg_port/src/en  shadow entry index, selected input, output enable
//   cfg_commit       request shadow -> active transfer
//   out_data/valid   N registered output channels (1-cycle latency)
//   cfg_pending      commit accepted, waiting for a gap cycle
//   cfg_err          one-cycle pulse: cfg_we/cfg_commit rejected while pending
module crossbar_nxn_shadow #(
  parameter  int W     = 4,
  parameter  int SEL_W = 2,
  localparam int N     = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N*W-1:0]   in_data,
  input  logic [N-1:0]     in_valid,
  input  logic             cfg_we,
  input  logic [SEL_W-1:0] cfg_port,
  input  logic [SEL_W-1:0] cfg_src,
  input  logic             cfg_en,
  input  logic             cfg_commit,
  output logic [N*W-1:0]   out_data,
  output logic [N-1:0]     out_valid,
  output logic             cfg_pending,
  output logic             cfg_err
);

  typedef enum logic {
    IDLE,
    PENDING
  } state_t;

  state_t state, state_nx;

  logic [N-1:0][SEL_W-1:0] shadow_src, shadow_src_nx, active_src;
  logic [N-1:0]            shadow_en, shadow_en_nx, active_en;
  logic                    no_traffic;
  logic                    load_active;
  logic                    err_nx;

  assign no_traffic  = (in_valid == '0);
  assign cfg_pending = (state == PENDING);

  // Controller and shadow-write logic. The shadow write is folded into
  // shadow_*_nx so that a commit issued in the same cycle as a write
  // carries that write into the active table.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_nx      = state;
    shadow_src_nx = shadow_src;
    shadow_en_nx  = shadow_en;
    load_active   = 1'b0;
    err_nx        = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_we) begin
          shadow_src_nx[cfg_port] = cfg_src;
          shadow_en_nx[cfg_port]  = cfg_en;
        end
        if (cfg_commit) begin
          if (no_traffic) load_active = 1'b1;   // gap now: zero-wait commit
          else            state_nx    = PENDING;
        end
      end
      PENDING: begin
        err_nx = cfg_we | cfg_commit;
        if (no_traffic) begin
          load_active = 1'b1;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Route tables. NOTE: both tables are a handful of flops, not a RAM, so
  // they are reset to the identity mapping directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < N; j++) begin
        shadow_src[j] <= SEL_W'(j);
        active_src[j] <= SEL_W'(j);
      end
      shadow_en <= '1;
      active_en <= '1;
      cfg_err   <= 1'b0;
    end else begin
      shadow_src <= shadow_src_nx;
      shadow_en  <= shadow_en_nx;
      if (load_active) begin
        active_src <= shadow_src_nx;
        active_en  <= shadow_en_nx;
      end
      cfg_err <= err_nx;
    end
  end

  // Data path: always driven from the active table as it stood before this
  // edge, so a table load only shows up one edge later and never splits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= '0;
    end else begin
      for (int j = 0; j < N; j++) begin
        out_data[j*W +: W] <= active_en[j] ? in_data[int'(active_src[j])*W +: W] : '0;
        out_valid[j]       <= active_en[j] & in_valid[active_src[j]];
      end
    end
  end

endmodule

// File: tb/tb_crossbar_nxn_shadow.sv
// Self-checking bench for crossbar_nxn_shadow: directed scenarios followed
// by a randomized phase, all compared against a table-level reference model.
module tb_crossbar_nxn_shadow;

  localparam int W     = 4;
  localparam int SEL_W = 2;
  localparam int N     = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic             cfg_we;
  logic [SEL_W-1:0] cfg_port;
  logic [SEL_W-1:0] cfg_src;
  logic             cfg_en;
  logic             cfg_commit;
  logic [N*W-1:0]   out_data;
  logic [N-1:0]     out_valid;
  logic             cfg_pending;
  logic             cfg_err;

  always #5 clk = ~clk;

  crossbar_nxn_shadow #(.W(W), .SEL_W(SEL_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .cfg_we      (cfg_we),
    .cfg_port    (cfg_port),
    .cfg_src     (cfg_src),
    .cfg_en      (cfg_en),
    .cfg_commit  (cfg_commit),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .cfg_pending (cfg_pending),
    .cfg_err     (cfg_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: two route tables plus a "commit waiting" flag.
  int             m_ssrc[N];
  int             m_asrc[N];
  bit             m_sen[N];
  bit             m_aen[N];
  bit             m_pend;
  logic [N*W-1:0] e_data;
  logic [N-1:0]   e_valid;
  logic           e_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < N; j++) begin
      m_ssrc[j] = j; m_asrc[j] = j;
      m_sen[j]  = 1; m_aen[j]  = 1;
    end
    m_pend = 0;
  endtask

  task automatic drive(input logic [N*W-1:0] d, input logic [N-1:0] v, input logic we,
                       input int port, input int src, input logic en, input logic commit);
    in_data    = d;
    in_valid   = v;
    cfg_we     = we;
    cfg_port   = SEL_W'(port);
    cfg_src    = SEL_W'(src);
    cfg_en     = en;
    cfg_commit = commit;
  endtask

  task automatic apply_commit();
    for (int j = 0; j < N; j++) begin
      m_asrc[j] = m_ssrc[j];
      m_aen[j]  = m_sen[j];
    end
  endtask

  // One clock: predict outputs from the tables as they stand, advance the
  // model, then compare just after the edge.
  task automatic tick(input string tag);
    for (int j = 0; j < N; j++) begin
      e_data[j*W +: W] = m_aen[j] ? in_data[m_asrc[j]*W +: W] : '0;
      e_valid[j]       = m_aen[j] & in_valid[m_asrc[j]];
    end
    e_err = m_pend && (cfg_we || cfg_commit);
    if (!m_pend) begin
      if (cfg_we) begin
        m_ssrc[cfg_port] = int'(cfg_src);
        m_sen[cfg_port]  = cfg_en;
      end
      if (cfg_commit) begin
        if (in_valid == '0) apply_commit();
        else                m_pend = 1;
      end
    end else if (in_valid == '0) begin
      apply_commit();
      m_pend = 0;
    end
    @(posedge clk);
    #1;
    check({tag, ".out_data"},  32'(out_data),    32'(e_data));
    check({tag, ".out_valid"}, 32'(out_valid),   32'(e_valid));
    check({tag, ".cfg_err"},   32'(cfg_err),     32'(e_err));
    check({tag, ".pending"},   32'(cfg_pending), 32'(m_pend));
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    check({tag, ".rst_data"},    32'(out_data),    32'h0);
    check({tag, ".rst_valid"},   32'(out_valid),   32'h0);
    check({tag, ".rst_pending"}, 32'(cfg_pending), 32'h0);
    check({tag, ".rst_err"},     32'(cfg_err),     32'h0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*W-1:0] d;

    rst_n = 1'b0;
    drive('0, '0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("reset.out_data",  32'(out_data),    32'h0);
    check("reset.out_valid", 32'(out_valid),   32'h0);
    check("reset.pending",   32'(cfg_pending), 32'h0);
    check("reset.cfg_err",   32'(cfg_err),     32'h0);
    rst_n = 1'b1;

    // Identity mapping straight out of reset.
    drive(16'h8421, 4'hF, 0, 0, 0, 0, 0);
    tick("ident");
    check("ident.const_data",  32'(out_data),  32'h8421);
    check("ident.const_valid", 32'(out_valid), 32'hF);

    // Reverse mapping, committed on a gap cycle (zero wait).
    for (int p = 0; p < N; p++) begin
      drive(N*W'($urandom), N'($urandom), 1, p, 3 - p, 1, 0);
      tick("rev_wr");
    end
    drive(16'h8421, 4'h0, 0, 0, 0, 0, 1);
    tick("rev_commit");
    check("rev.zero_wait", 32'(cfg_pending), 32'h0);
    drive(16'h8421, 4'hF, 0, 0, 0, 0, 0);
    tick("rev_data");
    check("rev.const_data", 32'(out_data), 32'h1248);

    // Broadcast input 2 to every output.
    for (int p = 0; p < N; p++) begin
      drive(N*W'($urandom), N'($urandom), 1, p, 2, 1, 0);
      tick("bc_wr");
    end
    drive(N*W'($urandom), 4'h0, 0, 0, 0, 0, 1);
    tick("bc_commit");
    d = N*W'($urandom);
    d[11:8] = 4'hA;
    drive(d, 4'h4, 0, 0, 0, 0, 0);
    tick("bc_data");
    check("bc.const_data",  32'(out_data),  32'hAAAA);
    check("bc.const_valid", 32'(out_valid), 32'hF);

    // Commit under traffic: waits three cycles, old (broadcast) map holds.
    for (int p = 0; p < N; p++) begin
      drive(N*W'($urandom), N'($urandom), 1, p, p, 1, 0);
      tick("wait_wr");
    end
    drive(N*W'($urandom), 4'h1, 0, 0, 0, 0, 1);
    tick("wait_c1");
    check("wait.pend1", 32'(cfg_pending), 32'h1);
    d = 16'h0B00;
    drive(d, 4'h1, 0, 0, 0, 0, 0);
    tick("wait_c2");
    check("wait.old_map", 32'(out_data), 32'hBBBB);
    drive(N*W'($urandom), 4'h1, 0, 0, 0, 0, 0);
    tick("wait_c3");
    check("wait.pend3", 32'(cfg_pending), 32'h1);
    drive(16'h8421, 4'h0, 0, 0, 0, 0, 0);
    tick("wait_gap");
    check("wait.applied", 32'(cfg_pending), 32'h0);
    drive(16'h8421, 4'hF, 0, 0, 0, 0, 0);
    tick("wait_new");
    check("wait.const_data", 32'(out_data), 32'h8421);

    // Write while pending is rejected and leaves the shadow untouched.
    drive(N*W'($urandom), 4'h2, 0, 0, 0, 0, 1);
    tick("rej_commit");
    drive(N*W'($urandom), 4'h2, 1, 0, 3, 1, 0);
    tick("rej_we");
    check("rej.err_pulse", 32'(cfg_err), 32'h1);
    drive(N*W'($urandom), 4'h2, 0, 0, 0, 0, 0);
    tick("rej_after");
    check("rej.err_clear", 32'(cfg_err), 32'h0);
    drive(16'h8421, 4'h0, 0, 0, 0, 0, 0);
    tick("rej_gap");
    drive(16'h8421, 4'hF, 0, 0, 0, 0, 0);
    tick("rej_data");
    check("rej.const_data", 32'(out_data), 32'h8421);

    // Disable output 1, then a reset pulse restores identity.
    drive(N*W'($urandom), 4'hF, 1, 1, 1, 0, 0);
    tick("dis_wr");
    drive(N*W'($urandom), 4'h0, 0, 0, 0, 0, 1);
    tick("dis_commit");
    d = 16'h9753;
    drive(d, 4'hF, 0, 0, 0, 0, 0);
    tick("dis_data");
    check("dis.const_data",  32'(out_data),  32'h9703);
    check("dis.const_valid", 32'(out_valid), 32'hD);
    reset_pulse("dis");
    drive(16'h8421, 4'hF, 0, 0, 0, 0, 0);
    tick("dis_ident");
    check("dis.ident_data", 32'(out_data), 32'h8421);

    // Reset while pending discards the commit.
    for (int p = 0; p < N; p++) begin
      drive(N*W'($urandom), 4'hF, 1, p, 3 - p, 1, 0);
      tick("rstp_wr");
    end
    drive(N*W'($urandom), 4'hF, 0, 0, 0, 0, 1);
    tick("rstp_commit");
    check("rstp.pend", 32'(cfg_pending), 32'h1);
    reset_pulse("rstp");
    drive(16'h8421, 4'h0, 0, 0, 0, 0, 0);
    tick("rstp_gap");
    drive(16'h8421, 4'hF, 0, 0, 0, 0, 0);
    tick("rstp_data");
    check("rstp.ident_data", 32'(out_data), 32'h8421);

    // Randomized traffic and configuration.
    for (int i = 0; i < 400; i++) begin
      drive(N*W'($urandom),
            ($urandom_range(0, 3) == 0) ? N'(0) : N'($urandom),
            1'($urandom_range(0, 2) == 0),
            int'($urandom_range(0, N - 1)),
            int'($urandom_range(0, N - 1)),
            1'($urandom_range(0, 4) != 0),
            1'($urandom_range(0, 5) == 0));
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crossbar_nxn_shadow.md
CROSSBAR_NXN_SHADOW -- requirements
Module: crossbar_nxn_shadow

Interface
REQ-001 The block SHALL have parameter W, default 4, meaning data width per channel in bits (1..32).
REQ-002 The block SHALL have parameter SEL_W, default 2, meaning select width; channel count N = 2**SEL_W (N = 4 by default).
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port in_data, input, N*W: input channel i occupies bits [i*W +: W].
REQ-006 Port in_valid, input, N: bit i qualifies input channel i.
REQ-007 Port cfg_we, input, 1: write one shadow route entry this cycle.
REQ-008 Port cfg_port, input, SEL_W: index of the output being configured.
REQ-009 Port cfg_src, input, SEL_W: index of the input to route to cfg_port.
REQ-010 Port cfg_en, input, 1: enable bit for cfg_port.
REQ-011 Port cfg_commit, input, 1: request transfer of the shadow table to the active table.
REQ-012 Port out_data, output, N*W: output channel j occupies bits [j*W +: W].
REQ-013 Port out_valid, output, N: bit j qualifies output channel j.
REQ-014 Port cfg_pending, output, 1: high while a commit is waiting to be applied.
REQ-015 Port cfg_err, output, 1: one-cycle pulse when a cfg_we or cfg_commit is rejected.

Function
REQ-016 The block SHALL hold two tables (shadow and active), each with, per output j, a SEL_W-bit source and a 1-bit enable.
REQ-017 A cfg_we in IDLE SHALL write {cfg_src, cfg_en} into shadow entry cfg_port at the clock edge; the active table SHALL be unaffected.
REQ-018 The output register SHALL load every cycle: out_data[j] <= active_en[j] ? in_data[active_src[j]] : 0, and out_valid[j] <= active_en[j] & in_valid[active_src[j]]; latency is exactly 1 cycle.
REQ-019 Broadcast SHALL be legal: any number of outputs may select the same input.
REQ-020 The controller SHALL be an FSM with states IDLE and PENDING; cfg_pending = (state == PENDING).
REQ-021 IDLE + cfg_commit SHALL move to PENDING; in the same cycle, a simultaneous cfg_we SHALL be written to shadow first, so it is included in the commit.
REQ-022 The commit SHALL be applied on a gap cycle: a cycle where in_valid == 0 and the FSM is in PENDING or is entering from IDLE with cfg_commit.
REQ-023 At the gap-cycle edge, the active table SHALL load the shadow table and the FSM SHALL return to (or remain in) IDLE.
REQ-024 A commit requested during a gap cycle SHALL apply at that edge (zero wait), with no cycle spent in PENDING.
REQ-025 The new routing SHALL first affect out_data/out_valid at the edge after the one that loaded the active table.
REQ-026 In PENDING, cfg_we and cfg_commit SHALL be ignored, and cfg_err SHALL pulse high for the following cycle (registered).
REQ-027 PENDING SHALL wait indefinitely with no timeout; the data path SHALL keep using the old active table while waiting.
REQ-028 The data path SHALL never mix the old and new tables within one cycle; all N outputs SHALL switch on the same edge.

Reset
REQ-029 On rst_n low, the block SHALL asynchronously set: shadow and active src[j] = j (identity), en[j] = 1, state IDLE, out_data = 0, out_valid = 0, cfg_err = 0.
REQ-030 Reset asserted in PENDING SHALL discard the pending commit and restore the identity mapping.
REQ-031 The first output update SHALL occur at the first rising edge after rst_n deasserts.

Verification
REQ-032 The bench SHALL cover: after reset, in_data = {4'h8,4'h4,4'h2,4'h1}, in_valid = 4'hF -> one cycle later out_data = {4'h8,4'h4,4'h2,4'h1} and out_valid = 4'hF.
REQ-033 The bench SHALL cover: cfg_we ports 0..3 with src = 3,2,1,0 (all en = 1), then cfg_commit with in_valid = 0 -> two edges later out_data = {4'h1,4'h2,4'h4,4'h8}.
REQ-034 The bench SHALL cover: broadcast, all outputs src = 2 and committed, with input 2 = 4'hA -> out_data = 16'hAAAA and out_valid = 4'hF when in_valid[2] = 1.
REQ-035 The bench SHALL cover: cfg_commit while in_valid = 4'h1 for 3 cycles -> cfg_pending high for 3 cycles; the old mapping holds; the table applies at the first in_valid = 0 cycle.
REQ-036 The bench SHALL cover: cfg_we during PENDING -> cfg_err pulses for 1 cycle, and after the commit the shadow entry is unchanged.
REQ-037 The bench SHALL cover: port 1 disabled (cfg_en = 0) and committed -> out_data[7:4] = 0 and out_valid[1] = 0 while the other ports pass data; an rst_n pulse then restores the identity mapping.
